// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Writer side of the instruction memory. It assembles a byte stream from the
//   debug UART into big-endian 32-bit words and writes them to consecutive
//   word addresses starting at 0. Loading stops after a HALT_WORD has been
//   written, or after the word at the last address below MEM_LIMIT.
//
//   Ports
//     Clock       : system clock, rising edge
//     Reset       : asynchronous reset, active low
//     Start       : one-cycle pulse, begins a load at address 0
//     RxData      : received byte
//     RxValid     : one-cycle strobe qualifying RxData
//     WriteEnable : memory write strobe, one cycle per word
//     WriteAddr   : byte address of the word being written (4-aligned)
//     WriteData   : assembled word
//     Loading     : load in progress (holds PC/pipeline in stall)
//     Done        : load finished; held until the next Start or Reset
//     Overflow    : load ended at the address limit without a halt word
//     WordCount   : words written in the current or last load
//
//   state   | meaning
//   S_IDLE  | after reset, waiting for Start
//   S_LOAD  | collecting bytes of the current word
//   S_WRITE | single write cycle; byte 0 of the next word may arrive here
//   S_DONE  | load complete; byte stream ignored until Start
module instr_mem_loader #(
  parameter logic [31:0] MEM_LIMIT = 32'h0000_07FF,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter int          CNT_W     = 10
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [7:0]       RxData,
  input  logic             RxValid,
  output logic             WriteEnable,
  output logic [31:0]      WriteAddr,
  output logic [31:0]      WriteData,
  output logic             Loading,
  output logic             Done,
  output logic             Overflow,
  output logic [CNT_W-1:0] WordCount
);

  localparam logic [31:0] LAST_ADDR = MEM_LIMIT - 32'd3;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        byte_cnt;
  logic [31:0]       shift_reg;
  logic [31:0]       word_reg;
  logic [31:0]       addr;
  logic [CNT_W-1:0]  word_count;
  logic              overflow_r;

  logic              clear_load;
  logic              shift_en;
  logic              latch_word;
  logic              write_cyc;
  logic              set_ovf;
  logic              adv_addr;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clear_load  = 1'b0;
    shift_en    = 1'b0;
    latch_word  = 1'b0;
    write_cyc   = 1'b0;
    set_ovf     = 1'b0;
    adv_addr    = 1'b0;
    WriteEnable = 1'b0;
    Loading     = 1'b0;
    Done        = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start) begin
          clear_load = 1'b1;
          state_nxt  = S_LOAD;
        end
      end
      S_LOAD: begin
        Loading = 1'b1;
        if (RxValid) begin
          shift_en = 1'b1;
          if (byte_cnt == 2'd3) begin
            latch_word = 1'b1;
            state_nxt  = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        Loading     = 1'b1;
        WriteEnable = 1'b1;
        write_cyc   = 1'b1;
        // byte_cnt is 0 here, so this byte can never complete a word
        shift_en    = RxValid;
        if (word_reg == HALT_WORD) begin
          state_nxt = S_DONE;
        end else if (addr == LAST_ADDR) begin
          set_ovf   = 1'b1;
          state_nxt = S_DONE;
        end else begin
          adv_addr  = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_DONE: begin
        Done = 1'b1;
        if (Start) begin
          clear_load = 1'b1;
          state_nxt  = S_LOAD;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      byte_cnt   <= 2'd0;
      shift_reg  <= 32'd0;
      word_reg   <= 32'd0;
      addr       <= 32'd0;
      word_count <= '0;
      overflow_r <= 1'b0;
    end else if (clear_load) begin
      // a Start also drops any partial word left over from the previous load
      byte_cnt   <= 2'd0;
      shift_reg  <= 32'd0;
      addr       <= 32'd0;
      word_count <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (shift_en) begin
        shift_reg <= {shift_reg[23:0], RxData};
        byte_cnt  <= byte_cnt + 2'd1;
      end
      if (latch_word) begin
        word_reg <= {shift_reg[23:0], RxData};
      end
      if (write_cyc) begin
        word_count <= word_count + CNT_W'(1);
      end
      if (set_ovf) begin
        overflow_r <= 1'b1;
      end
      if (adv_addr) begin
        addr <= addr + 32'd4;
      end
    end
  end

  assign WriteAddr = addr;
  assign WriteData = word_reg;
  assign Overflow  = overflow_r;
  assign WordCount = word_count;

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [7:0]  RxData;
  logic        RxValid;
  logic        WriteEnable;
  logic [31:0] WriteAddr;
  logic [31:0] WriteData;
  logic        Loading;
  logic        Done;
  logic        Overflow;
  logic [9:0]  WordCount;

  int n_cmp = 0;
  int n_bad = 0;
  int cycle = 0;
  int we_consec = 0;
  logic prev_we = 1'b0;

  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];

  instr_mem_loader dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .RxData(RxData), .RxValid(RxValid),
    .WriteEnable(WriteEnable), .WriteAddr(WriteAddr), .WriteData(WriteData),
    .Loading(Loading), .Done(Done), .Overflow(Overflow), .WordCount(WordCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cycle++;

  // write monitor: captures every write and flags back-to-back strobes
  always @(negedge Clock) begin
    if (WriteEnable === 1'b1) begin
      wq_addr.push_back(WriteAddr);
      wq_data.push_back(WriteData);
      wq_cyc.push_back(cycle);
    end
    if (prev_we === 1'b1 && WriteEnable === 1'b1) we_consec++;
    prev_we = WriteEnable;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic clear_q();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, output int edge_no);
    RxData  = b;
    RxValid = 1'b1;
    tick();
    edge_no = cycle;
    RxValid = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic reset_dut();
    Reset = 1'b0;
    repeat (3) tick();
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    int e;
    Reset = 1'b0;
    repeat (3) tick();
    @(negedge Clock);
    n_cmp++; if (Loading !== 1'b0) begin n_bad++; $display("FAIL rst_loading got=%0h exp=0", Loading); end
    n_cmp++; if (WriteData !== 32'd0) begin n_bad++; $display("FAIL rst_wdata got=%h exp=0", WriteData); end
    #1;
    Reset = 1'b1;
    clear_q();
    repeat (2) tick();
    send_byte(8'h12, e);
    send_byte(8'h34, e);
    send_byte(8'h56, e);
    send_byte(8'h78, e);
    tick();
    @(negedge Clock);
    n_cmp++; if (WriteEnable !== 1'b0) begin n_bad++; $display("FAIL idle_we got=%0h exp=0", WriteEnable); end
    n_cmp++; if (WriteAddr !== 32'd0) begin n_bad++; $display("FAIL idle_waddr got=%h exp=0", WriteAddr); end
    n_cmp++; if (WriteData !== 32'd0) begin n_bad++; $display("FAIL idle_wdata got=%h exp=0", WriteData); end
    n_cmp++; if (Loading !== 1'b0) begin n_bad++; $display("FAIL idle_loading got=%0h exp=0", Loading); end
    n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("FAIL idle_done got=%0h exp=0", Done); end
    n_cmp++; if (Overflow !== 1'b0) begin n_bad++; $display("FAIL idle_ovf got=%0h exp=0", Overflow); end
    n_cmp++; if (WordCount !== 10'd0) begin n_bad++; $display("FAIL idle_wcount got=%0d exp=0", WordCount); end
    n_cmp++; if (wq_addr.size() != 0) begin n_bad++; $display("FAIL idle_writes got=%0d exp=0", wq_addr.size()); end
    #1;
  endtask

  task automatic test_basic();
    logic [7:0]  bytes [12] = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h07,
                                8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [31:0] exp_a [3] = '{32'h0, 32'h4, 32'h8};
    logic [31:0] exp_d [3] = '{32'h2001_0005, 32'h2002_0007, 32'hFFFF_FFFF};
    int exp_c [3];
    int e;
    clear_q();
    pulse_start();
    @(negedge Clock);
    n_cmp++; if (Loading !== 1'b1) begin n_bad++; $display("FAIL basic_loading got=%0h exp=1", Loading); end
    #1;
    for (int i = 0; i < 12; i++) begin
      send_byte(bytes[i], e);
      if (i % 4 == 3) exp_c[i / 4] = e;
      tick();
    end
    repeat (2) tick();
    @(negedge Clock);
    n_cmp++; if (wq_addr.size() != 3) begin n_bad++; $display("FAIL basic_nwrites got=%0d exp=3", wq_addr.size()); end
    for (int i = 0; i < 3 && i < wq_addr.size(); i++) begin
      n_cmp++; if (wq_addr[i] !== exp_a[i]) begin n_bad++; $display("FAIL basic_addr[%0d] got=%h exp=%h", i, wq_addr[i], exp_a[i]); end
      n_cmp++; if (wq_data[i] !== exp_d[i]) begin n_bad++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, wq_data[i], exp_d[i]); end
      n_cmp++; if (wq_cyc[i] != exp_c[i]) begin n_bad++; $display("FAIL basic_latency[%0d] got=%0d exp=%0d", i, wq_cyc[i], exp_c[i]); end
    end
    n_cmp++; if (Done !== 1'b1) begin n_bad++; $display("FAIL basic_done got=%0h exp=1", Done); end
    n_cmp++; if (Overflow !== 1'b0) begin n_bad++; $display("FAIL basic_ovf got=%0h exp=0", Overflow); end
    n_cmp++; if (WordCount !== 10'd3) begin n_bad++; $display("FAIL basic_wcount got=%0d exp=3", WordCount); end
    n_cmp++; if (Loading !== 1'b0) begin n_bad++; $display("FAIL basic_loading_end got=%0h exp=0", Loading); end
    #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  bytes [12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                                8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [31:0] exp_d [3] = '{32'h1122_3344, 32'h5566_7788, 32'hFFFF_FFFF};
    int first_c;
    int e;
    clear_q();
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      send_byte(bytes[i], e);
      if (i == 3) first_c = e;
    end
    repeat (2) tick();
    @(negedge Clock);
    n_cmp++; if (wq_addr.size() != 3) begin n_bad++; $display("FAIL b2b_nwrites got=%0d exp=3", wq_addr.size()); end
    for (int i = 0; i < 3 && i < wq_addr.size(); i++) begin
      n_cmp++; if (wq_data[i] !== exp_d[i]) begin n_bad++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, wq_data[i], exp_d[i]); end
      n_cmp++; if (wq_addr[i] !== 32'(4 * i)) begin n_bad++; $display("FAIL b2b_addr[%0d] got=%h exp=%h", i, wq_addr[i], 4 * i); end
      n_cmp++; if (wq_cyc[i] != first_c + 4 * i) begin n_bad++; $display("FAIL b2b_spacing[%0d] got=%0d exp=%0d", i, wq_cyc[i], first_c + 4 * i); end
    end
    n_cmp++; if (WordCount !== 10'd3) begin n_bad++; $display("FAIL b2b_wcount got=%0d exp=3", WordCount); end
    n_cmp++; if (Done !== 1'b1) begin n_bad++; $display("FAIL b2b_done got=%0h exp=1", Done); end
    #1;
  endtask

  task automatic test_overflow();
    int e;
    int bad_seq;
    clear_q();
    pulse_start();
    for (int i = 0; i < 2048; i++) send_byte(8'h00, e);
    repeat (2) tick();
    @(negedge Clock);
    n_cmp++; if (wq_addr.size() != 512) begin n_bad++; $display("FAIL ovf_nwrites got=%0d exp=512", wq_addr.size()); end
    bad_seq = 0;
    for (int i = 0; i < wq_addr.size(); i++)
      if (wq_addr[i] !== 32'(4 * i) || wq_data[i] !== 32'd0) bad_seq++;
    n_cmp++; if (bad_seq != 0) begin n_bad++; $display("FAIL ovf_sequence got=%0d bad exp=0", bad_seq); end
    if (wq_addr.size() > 0) begin
      n_cmp++; if (wq_addr[wq_addr.size() - 1] !== 32'h7FC) begin n_bad++; $display("FAIL ovf_last_addr got=%h exp=7fc", wq_addr[wq_addr.size() - 1]); end
    end
    n_cmp++; if (Done !== 1'b1) begin n_bad++; $display("FAIL ovf_done got=%0h exp=1", Done); end
    n_cmp++; if (Overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got=%0h exp=1", Overflow); end
    n_cmp++; if (WordCount !== 10'd512) begin n_bad++; $display("FAIL ovf_wcount got=%0d exp=512", WordCount); end
    n_cmp++; if (Loading !== 1'b0) begin n_bad++; $display("FAIL ovf_loading got=%0h exp=0", Loading); end
    #1;
    for (int i = 0; i < 8; i++) send_byte(8'hFF, e);
    repeat (2) tick();
    n_cmp++; if (wq_addr.size() != 512) begin n_bad++; $display("FAIL ovf_after_done got=%0d exp=512", wq_addr.size()); end
  endtask

  task automatic test_start_in_done();
    int e;
    clear_q();
    pulse_start();
    @(negedge Clock);
    n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("FAIL restart_done got=%0h exp=0", Done); end
    n_cmp++; if (Overflow !== 1'b0) begin n_bad++; $display("FAIL restart_ovf got=%0h exp=0", Overflow); end
    n_cmp++; if (WordCount !== 10'd0) begin n_bad++; $display("FAIL restart_wcount got=%0d exp=0", WordCount); end
    n_cmp++; if (Loading !== 1'b1) begin n_bad++; $display("FAIL restart_loading got=%0h exp=1", Loading); end
    #1;
    send_byte(8'hDE, e);
    send_byte(8'hAD, e);
    send_byte(8'hBE, e);
    send_byte(8'hEF, e);
    repeat (2) tick();
    n_cmp++; if (wq_addr.size() != 1) begin n_bad++; $display("FAIL restart_nwrites got=%0d exp=1", wq_addr.size()); end
    if (wq_addr.size() > 0) begin
      n_cmp++; if (wq_addr[0] !== 32'h0) begin n_bad++; $display("FAIL restart_addr got=%h exp=0", wq_addr[0]); end
      n_cmp++; if (wq_data[0] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL restart_data got=%h exp=deadbeef", wq_data[0]); end
    end
  endtask

  task automatic test_start_collide();
    int e;
    reset_dut();
    clear_q();
    Start   = 1'b1;
    RxData  = 8'hAA;
    RxValid = 1'b1;
    tick();
    Start   = 1'b0;
    RxValid = 1'b0;
    send_byte(8'h01, e);
    send_byte(8'h02, e);
    send_byte(8'h03, e);
    send_byte(8'h04, e);
    repeat (2) tick();
    @(negedge Clock);
    n_cmp++; if (wq_addr.size() != 1) begin n_bad++; $display("FAIL collide_nwrites got=%0d exp=1", wq_addr.size()); end
    if (wq_addr.size() > 0) begin
      n_cmp++; if (wq_data[0] !== 32'h0102_0304) begin n_bad++; $display("FAIL collide_data got=%h exp=01020304", wq_data[0]); end
      n_cmp++; if (wq_addr[0] !== 32'h0) begin n_bad++; $display("FAIL collide_addr got=%h exp=0", wq_addr[0]); end
    end
    n_cmp++; if (WordCount !== 10'd1) begin n_bad++; $display("FAIL collide_wcount got=%0d exp=1", WordCount); end
    n_cmp++; if (Loading !== 1'b1) begin n_bad++; $display("FAIL collide_loading got=%0h exp=1", Loading); end
    #1;
  endtask

  task automatic test_reset_mid();
    int e;
    reset_dut();
    pulse_start();
    send_byte(8'h99, e);
    send_byte(8'h88, e);
    send_byte(8'h77, e);
    send_byte(8'h66, e);
    send_byte(8'h55, e);
    send_byte(8'h44, e);
    #2;
    Reset = 1'b0;
    #1;
    n_cmp++; if (Loading !== 1'b0) begin n_bad++; $display("FAIL midrst_loading got=%0h exp=0", Loading); end
    n_cmp++; if (WordCount !== 10'd0) begin n_bad++; $display("FAIL midrst_wcount got=%0d exp=0", WordCount); end
    n_cmp++; if (WriteData !== 32'd0) begin n_bad++; $display("FAIL midrst_wdata got=%h exp=0", WriteData); end
    n_cmp++; if (WriteAddr !== 32'd0) begin n_bad++; $display("FAIL midrst_waddr got=%h exp=0", WriteAddr); end
    repeat (2) tick();
    Reset = 1'b1;
    clear_q();
    tick();
    pulse_start();
    send_byte(8'hCA, e);
    send_byte(8'hFE, e);
    send_byte(8'hBA, e);
    send_byte(8'hBE, e);
    repeat (2) tick();
    n_cmp++; if (wq_addr.size() != 1) begin n_bad++; $display("FAIL midrst_nwrites got=%0d exp=1", wq_addr.size()); end
    if (wq_addr.size() > 0) begin
      n_cmp++; if (wq_addr[0] !== 32'h0) begin n_bad++; $display("FAIL midrst_addr got=%h exp=0", wq_addr[0]); end
      n_cmp++; if (wq_data[0] !== 32'hCAFE_BABE) begin n_bad++; $display("FAIL midrst_data got=%h exp=cafebabe", wq_data[0]); end
    end
  endtask

  initial begin
    Reset   = 1'b0;
    Start   = 1'b0;
    RxData  = 8'h00;
    RxValid = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_start_in_done();
    test_start_collide();
    test_reset_mid();
    n_cmp++; if (we_consec != 0) begin n_bad++; $display("FAIL we_consecutive got=%0d exp=0", we_consec); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
